// File: rtl/seg_disp_pkg.sv
// Shared constants, glyph table and FSM state type for the segment display bank.
package seg_disp_pkg;

    localparam int SEG_WORDS = 16;
    localparam int SEG_IDX_W = 4;

    localparam logic [31:0] SEG_BLANK_WORD = 32'hFCFCFCFC;

    // Glyph for nibble n sits at bits [8n+7:8n]; byte layout {a,b,c,d,e,f,g,dp}.
    localparam logic [127:0] SEG_GLYPHS = {
        8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
        8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
    };

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } seg_state_t;

    function automatic logic [7:0] seg_glyph(input logic [3:0] nib);
        return SEG_GLYPHS[{nib, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/seg_hex_enc.sv
// Nibble to 7-segment glyph encoder.
module seg_hex_enc
    import seg_disp_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] glyph_o
);

    assign glyph_o = seg_glyph(nib_i);

endmodule

// File: rtl/seg_word_scheduler.sv
// Two-port arbitrated writer and bank clear sequencer for the 16-word display bank.
// Define SEG_HEX_DECODE_EN to store hex glyphs of DATA[15:0] instead of raw words.
module seg_word_scheduler
    import seg_disp_pkg::*;
#(
    parameter int          NUM_WORDS  = SEG_WORDS,
    parameter logic [31:0] RESET_WORD = SEG_BLANK_WORD
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    REQ0_VALID,
    input  logic [SEG_IDX_W-1:0]    REQ0_IDX,
    input  logic [31:0]             REQ0_DATA,
    output logic                    REQ0_READY,
    input  logic                    REQ1_VALID,
    input  logic [SEG_IDX_W-1:0]    REQ1_IDX,
    input  logic [31:0]             REQ1_DATA,
    output logic                    REQ1_READY,
    input  logic                    CLR,
    output logic                    BUSY,
    output logic [15:0]             WR_COUNT,
    output logic [NUM_WORDS*32-1:0] SEG_BUS
);

    seg_state_t             state_q, state_d;
    logic                   rr_q, rr_d;
    logic [SEG_IDX_W-1:0]   clr_idx_q, clr_idx_d;
    logic [15:0]            wr_count_q, wr_count_d;
    logic [NUM_WORDS*32-1:0] bank_q, bank_d;

    logic                   idle;
    logic                   grant;
    logic                   accept;
    logic [SEG_IDX_W-1:0]   widx;
    logic [31:0]            wraw;
    logic [31:0]            wword;

    assign idle       = (state_q == ST_IDLE);
    // A lone requester always wins; rr only breaks ties.
    assign grant      = (REQ0_VALID && REQ1_VALID) ? rr_q : REQ1_VALID;
    assign REQ0_READY = idle && !CLR && !grant && REQ0_VALID;
    assign REQ1_READY = idle && !CLR && grant && REQ1_VALID;
    assign accept     = REQ0_READY || REQ1_READY;
    assign widx       = grant ? REQ1_IDX : REQ0_IDX;
    assign wraw       = grant ? REQ1_DATA : REQ0_DATA;

`ifdef SEG_HEX_DECODE_EN
    for (genvar g = 0; g < 4; g++) begin : g_enc
        seg_hex_enc u_enc (
            .nib_i   (wraw[4*g +: 4]),
            .glyph_o (wword[8*g +: 8])
        );
    end
`else
    assign wword = wraw;
`endif

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        clr_idx_d  = clr_idx_q;
        wr_count_d = wr_count_q;
        bank_d     = bank_q;
        unique case (state_q)
            ST_IDLE: begin
                if (CLR) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end else if (accept) begin
                    bank_d[{widx, 5'd0} +: 32] = wword;
                    wr_count_d = wr_count_q + 16'd1;
                    rr_d       = ~grant;
                end
            end
            ST_CLEAR: begin
                bank_d[{clr_idx_q, 5'd0} +: 32] = RESET_WORD;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == SEG_IDX_W'(NUM_WORDS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            rr_q       <= 1'b0;
            clr_idx_q  <= '0;
            wr_count_q <= '0;
            bank_q     <= {NUM_WORDS{RESET_WORD}};
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            clr_idx_q  <= clr_idx_d;
            wr_count_q <= wr_count_d;
            bank_q     <= bank_d;
        end
    end

    assign BUSY     = (state_q == ST_CLEAR);
    assign WR_COUNT = wr_count_q;
    assign SEG_BUS  = bank_q;

endmodule

// File: tb/tb_seg_word_scheduler.sv
// Directed bench for seg_word_scheduler with a per-cycle reference model.
module tb_seg_word_scheduler;

    localparam logic [31:0] BLANK = 32'hFCFCFCFC;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         REQ0_VALID = 1'b0;
    logic [3:0]   REQ0_IDX = '0;
    logic [31:0]  REQ0_DATA = '0;
    logic         REQ0_READY;
    logic         REQ1_VALID = 1'b0;
    logic [3:0]   REQ1_IDX = '0;
    logic [31:0]  REQ1_DATA = '0;
    logic         REQ1_READY;
    logic         CLR = 1'b0;
    logic         BUSY;
    logic [15:0]  WR_COUNT;
    logic [511:0] SEG_BUS;

    int errors = 0;
    int checks = 0;

    seg_word_scheduler dut (
        .CLK        (CLK),
        .RST        (RST),
        .REQ0_VALID (REQ0_VALID),
        .REQ0_IDX   (REQ0_IDX),
        .REQ0_DATA  (REQ0_DATA),
        .REQ0_READY (REQ0_READY),
        .REQ1_VALID (REQ1_VALID),
        .REQ1_IDX   (REQ1_IDX),
        .REQ1_DATA  (REQ1_DATA),
        .REQ1_READY (REQ1_READY),
        .CLR        (CLR),
        .BUSY       (BUSY),
        .WR_COUNT   (WR_COUNT),
        .SEG_BUS    (SEG_BUS)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_word(input int k, input logic [31:0] exp);
        chk($sformatf("word%0d", k), 512'(SEG_BUS[32*k +: 32]), 512'(exp));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [7:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 8'hFC; 4'h1: return 8'h60; 4'h2: return 8'hDA; 4'h3: return 8'hF2;
            4'h4: return 8'h66; 4'h5: return 8'hB6; 4'h6: return 8'hBE; 4'h7: return 8'hE0;
            4'h8: return 8'hFE; 4'h9: return 8'hF6; 4'hA: return 8'hEE; 4'hB: return 8'h3E;
            4'hC: return 8'h9C; 4'hD: return 8'h7A; 4'hE: return 8'h9E; default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [31:0] stored(input logic [31:0] d);
`ifdef SEG_HEX_DECODE_EN
        return {glyph(d[15:12]), glyph(d[11:8]), glyph(d[7:4]), glyph(d[3:0])};
`else
        return d;
`endif
    endfunction

    // Reference model: bank contents, write count, tie-break owner, clear cycles left.
    logic [31:0] m_bank [16];
    logic [15:0] m_count;
    logic        m_rr;
    int          m_left;
    bit          m_live = 0;

    always @(posedge CLK) begin
        if (!RST) begin
            for (int k = 0; k < 16; k++) m_bank[k] = BLANK;
            m_count = '0;
            m_rr    = 1'b0;
            m_left  = 0;
            m_live  = 1;
        end else if (m_live) begin
            if (m_left > 0) begin
                m_bank[16 - m_left] = BLANK;
                m_left--;
            end else if (CLR) begin
                m_left = 16;
            end else if (REQ0_VALID && (!REQ1_VALID || !m_rr)) begin
                m_bank[REQ0_IDX] = stored(REQ0_DATA);
                m_count++;
                m_rr = 1'b1;
            end else if (REQ1_VALID) begin
                m_bank[REQ1_IDX] = stored(REQ1_DATA);
                m_count++;
                m_rr = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (m_live) begin
            logic [511:0] eb;
            logic         e0, e1;
            for (int k = 0; k < 16; k++) eb[32*k +: 32] = m_bank[k];
            e0 = (m_left == 0) && !CLR && REQ0_VALID && (!REQ1_VALID || !m_rr);
            e1 = (m_left == 0) && !CLR && REQ1_VALID && (!REQ0_VALID || m_rr);
            chk("model_bus", SEG_BUS, eb);
            chk("model_busy", 512'(BUSY), 512'(m_left > 0));
            chk("model_count", 512'(WR_COUNT), 512'(m_count));
            chk("model_ready0", 512'(REQ0_READY), 512'(e0));
            chk("model_ready1", 512'(REQ1_READY), 512'(e1));
            chk("ready_exclusive", 512'(REQ0_READY && REQ1_READY), 512'(0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          busy_n;
        int          acc;
        logic [31:0] exp_a;
        logic [31:0] exp_5;
        exp_a = stored(32'hAAAAAAAA);
        exp_5 = stored(32'h55555555);

        tick();
        tick();
        RST = 1'b1;
        repeat (5) tick();
        for (int k = 0; k < 16; k++) chk_word(k, BLANK);
        chk("reset_busy", 512'(BUSY), 512'(0));
        chk("reset_count", 512'(WR_COUNT), 512'(0));

        REQ0_VALID = 1'b1; REQ0_IDX = 4'd3; REQ0_DATA = 32'h12345678;
        #1;
        chk("single_ready0", 512'(REQ0_READY), 512'(1));
        tick();
        REQ0_VALID = 1'b0;
        chk_word(3, stored(32'h12345678));
        chk_word(2, BLANK);
        chk("single_count", 512'(WR_COUNT), 512'(1));

        RST = 1'b0;
        tick();
        RST = 1'b1;
        REQ0_VALID = 1'b1; REQ0_IDX = 4'd0; REQ0_DATA = 32'h11110000;
        REQ1_VALID = 1'b1; REQ1_IDX = 4'd1; REQ1_DATA = 32'h22220001;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("grant%0d", i), 512'({REQ1_READY, REQ0_READY}),
                512'((i % 2) ? 2'b10 : 2'b01));
            tick();
        end
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        chk("arb_count", 512'(WR_COUNT), 512'(4));
        chk_word(0, stored(32'h11110000));
        chk_word(1, stored(32'h22220001));

        REQ0_VALID = 1'b1; REQ0_DATA = 32'hAAAAAAAA;
        for (int i = 0; i < 16; i++) begin
            REQ0_IDX = 4'(i);
            tick();
        end
        REQ0_VALID = 1'b0;
        chk_word(9, exp_a);
        chk("fill_count", 512'(WR_COUNT), 512'(20));

        CLR = 1'b1;
        REQ1_VALID = 1'b1; REQ1_IDX = 4'd5; REQ1_DATA = 32'h55555555;
        #1;
        chk("clr_blocks_ready1", 512'(REQ1_READY), 512'(0));
        tick();
        CLR = 1'b0;
        busy_n = 0;
        acc = -1;
        for (int k = 0; k < 40; k++) begin
            if (BUSY) busy_n++;
            if (REQ1_READY) begin
                acc = k;
                break;
            end
            tick();
        end
        chk("clear_busy_cycles", 512'(busy_n), 512'(16));
        chk("clear_accept_edge", 512'(acc), 512'(16));
        chk("clear_bank", SEG_BUS, {16{BLANK}});
        tick();
        REQ1_VALID = 1'b0;
        chk_word(5, exp_5);
        chk("post_clear_count", 512'(WR_COUNT), 512'(21));

        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        repeat (7) tick();
        chk("mid_clear_busy", 512'(BUSY), 512'(1));
        RST = 1'b0;
        tick();
        RST = 1'b1;
        chk("abort_bank", SEG_BUS, {16{BLANK}});
        chk("abort_busy", 512'(BUSY), 512'(0));
        chk("abort_count", 512'(WR_COUNT), 512'(0));

`ifdef SEG_HEX_DECODE_EN
        REQ0_VALID = 1'b1; REQ0_IDX = 4'd15; REQ0_DATA = 32'h00000A5F;
        tick();
        REQ0_VALID = 1'b0;
        chk_word(15, 32'hFCEEB68E);
`endif

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
